// File: rtl/main_mem_responder.sv
// Word-addressed RAM behind a valid/ready bus; each access is acknowledged after a fixed latency.
// Optional MAIN_MEM_STATS_EN adds saturating read/write/stall statistics outputs.
module main_mem_responder #(
    parameter int             N         = 32,
    parameter int             MEM_WORDS = 4096,
    parameter int             LATENCY   = 3,
    parameter logic [N-1:0]   OOR_RDATA = 32'hDEAD_BEEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_valid,
    input  logic [N-1:0]     mem_addr,
    input  logic [3:0]       mem_wstrb,
    input  logic [N-1:0]     mem_wdata,
    output logic             mem_ready,
    output logic [N-1:0]     mem_rdata,
    output logic             oor_err
`ifdef MAIN_MEM_STATS_EN
    ,
    output logic [31:0]      rd_count,
    output logic [31:0]      wr_count,
    output logic [31:0]      stall_cycles
`endif
);

    if ((LATENCY < 1) || (LATENCY > 15)) begin : g_bad_latency
        $fatal(1, "main_mem_responder: LATENCY must be within 1..15");
    end

    localparam int           AW          = $clog2(MEM_WORDS);
    localparam logic [3:0]   LAT_M1      = 4'(LATENCY - 1);
    localparam logic [N-1:0] MEM_WORDS_W = N'(MEM_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [N-3:0]    widx_q;
    logic [3:0]      wstrb_q;
    logic [N-1:0]    wdata_q;
    logic            ready_q;
    logic [N-1:0]    rdata_q;
    logic            oor_q;
    logic            capture_s;
    logic            commit_s;
    logic            oor_s;
    logic            is_wr_s;
    logic [AW-1:0]   idx_s;
    logic            unused_addr_s;

    // RAM is not cleared by reset; it only starts out zeroed.
    logic [N-1:0]    mem_q [MEM_WORDS] = '{default: '0};

    assign unused_addr_s = ^mem_addr[1:0];
    assign oor_s         = ({2'b00, widx_q} >= MEM_WORDS_W);
    assign is_wr_s       = (wstrb_q != 4'b0000);
    assign idx_s         = widx_q[AW-1:0];

    // Next-state logic: capture in IDLE, count down in WAIT (abort if valid drops), single-cycle RESP.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_s = 1'b0;
        commit_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    state_d   = ST_WAIT;
                    cnt_d     = LAT_M1;
                    capture_s = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!mem_valid) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d  = ST_RESP;
                    commit_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Control state, request holding registers and the registered response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            widx_q  <= '0;
            wstrb_q <= 4'b0000;
            wdata_q <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= commit_s;
            oor_q   <= oor_q | (commit_s & oor_s);
            if (capture_s) begin
                widx_q  <= mem_addr[N-1:2];
                wstrb_q <= mem_wstrb;
                wdata_q <= mem_wdata;
            end
            if (commit_s) begin
                if (is_wr_s) begin
                    rdata_q <= '0;
                end else if (oor_s) begin
                    rdata_q <= OOR_RDATA;
                end else begin
                    rdata_q <= mem_q[idx_s];
                end
            end
        end
    end

    // Byte-lane write commit on the edge entering RESP; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (!reset && commit_s && is_wr_s && !oor_s) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) begin
                    mem_q[idx_s][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign oor_err   = oor_q;

`ifdef MAIN_MEM_STATS_EN
    logic [31:0] rd_q, wr_q, stall_q;
    logic [32:0] stall_sum_s;

    // Stalls are the wait cycles beyond the first, credited only when an access completes.
    assign stall_sum_s = {1'b0, stall_q} + 33'(LAT_M1);

    // Saturating statistics; aborted requests never reach commit and so are never counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q    <= 32'd0;
            wr_q    <= 32'd0;
            stall_q <= 32'd0;
        end else if (commit_s) begin
            if (is_wr_s) begin
                wr_q <= (wr_q == 32'hFFFF_FFFF) ? wr_q : wr_q + 32'd1;
            end else begin
                rd_q <= (rd_q == 32'hFFFF_FFFF) ? rd_q : rd_q + 32'd1;
            end
            stall_q <= stall_sum_s[32] ? 32'hFFFF_FFFF : stall_sum_s[31:0];
        end
    end

    assign rd_count     = rd_q;
    assign wr_count     = wr_q;
    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_main_mem_responder.sv
// Scoreboard bench for main_mem_responder: a driver issues directed and random accesses and
// queues expectations from an array-based memory model; a negedge monitor checks every ack.
module tb_main_mem_responder;
    localparam int LAT   = 3;
    localparam int WORDS = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        oor_err;

    main_mem_responder #(.N(32), .MEM_WORDS(WORDS), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .oor_err(oor_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        oor;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    bit   [31:0] model_mem [WORDS];
    bit          model_oor = 1'b0;
    int          cyc = 0;
    int          ack_cnt = 0;
    int          base_ack = 0;
    int          n_vec = 0;
    int          n_fail = 0;
    logic [31:0] last_rdata = 32'd0;
    logic        prev_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack must match the head of the expectation queue, at the predicted cycle.
    always @(negedge clk) begin
        if (!reset && mem_ready) begin
            exp_t e;
            ack_cnt++;
            chk("ready_not_back_to_back", 32'(prev_ready), 32'd0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_ack: got ready=1 expected no ack (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("rdata", mem_rdata, e.rdata);
                chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                chk("oor_err", 32'(oor_err), 32'(e.oor));
                last_rdata = mem_rdata;
            end
        end
        prev_ready = reset ? 1'b0 : mem_ready;
    end

    // Drive a request; when tracked, the model computes the response and commits writes.
    task automatic issue(input logic [31:0] addr, input logic [3:0] strb,
                         input logic [31:0] data, input bit track);
        exp_t        e;
        logic [29:0] word;
        bit          oor;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wstrb = strb;
        mem_wdata = data;
        base_ack  = ack_cnt;
        if (track) begin
            word = addr[31:2];
            oor  = (int'(word) >= WORDS);
            if (strb == 4'd0) begin
                e.rdata = oor ? 32'hDEAD_BEEF : model_mem[word[11:0]];
            end else begin
                e.rdata = 32'd0;
                if (!oor) begin
                    for (int b = 0; b < 4; b++)
                        if (strb[b]) model_mem[word[11:0]][8*b +: 8] = data[8*b +: 8];
                end
            end
            model_oor = model_oor | oor;
            e.oor = model_oor;
            e.cyc = cyc + 1 + LAT;
            exp_q.push_back(e);
        end
    endtask

    // Wait (bounded) for the ack, then return #1 after the edge that ends the RESP cycle.
    task automatic wait_ack(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            if (ack_cnt != base_ack) got = 1'b1;
        end
        #1;
        if (!got) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s_timeout: got no ack expected ack within 40 cycles", name);
            mem_valid = 1'b0;
            exp_q.delete();
        end
    endtask

    task automatic idle(input int n);
        mem_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic abort_req(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data);
        issue(addr, strb, data, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 mem_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_ack", 32'(ack_cnt), 32'(base_ack));
    endtask

    initial begin
        reset = 1'b1; mem_valid = 1'b0; mem_addr = 32'd0; mem_wstrb = 4'd0; mem_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_ready", 32'(mem_ready), 32'd0);
        chk("reset_rdata", mem_rdata, 32'd0);
        chk("reset_oor", 32'(oor_err), 32'd0);

        // Preload, read latency, byte-strobe merge.
        issue(32'h14, 4'hF, 32'h1234_5678, 1'b1); wait_ack("preload"); idle(1);
        issue(32'h14, 4'h0, 32'd0, 1'b1);         wait_ack("read5");   idle(1);
        chk("read5_value", last_rdata, 32'h1234_5678);
        issue(32'h14, 4'b0101, 32'hAABB_CCDD, 1'b1); wait_ack("strb_wr"); idle(2);
        issue(32'h14, 4'h0, 32'd0, 1'b1);         wait_ack("merge");   idle(1);
        chk("merge_value", last_rdata, 32'h12BB_56DD);

        // Cache-style burst with valid held high across the ready edge.
        issue(32'h40, 4'hF, 32'hCAFE_0010, 1'b1); wait_ack("pre16"); idle(1);
        issue(32'h44, 4'hF, 32'hCAFE_0011, 1'b1); wait_ack("pre17"); idle(1);
        issue(32'h40, 4'h0, 32'd0, 1'b1);         wait_ack("burst0");
        issue(32'h44, 4'h0, 32'd0, 1'b1);         wait_ack("burst1"); idle(1);
        chk("burst1_value", last_rdata, 32'hCAFE_0011);

        // Out-of-range read, then in-range access with sticky flag.
        issue(WORDS * 4, 4'h0, 32'd0, 1'b1); wait_ack("oor_rd"); idle(1);
        chk("oor_value", last_rdata, 32'hDEAD_BEEF);
        issue(32'h40, 4'h0, 32'd0, 1'b1);    wait_ack("after_oor"); idle(1);
        chk("oor_sticky", 32'(oor_err), 32'd1);

        // Aborted write leaves RAM unchanged.
        abort_req(32'h14, 4'hF, 32'hFFFF_FFFF);
        issue(32'h14, 4'h0, 32'd0, 1'b1); wait_ack("after_abort"); idle(1);

        // Reset during WAIT of a write: nothing committed, flag cleared.
        issue(32'h14, 4'hF, 32'h0BAD_0BAD, 1'b0);
        @(posedge clk);
        #1 begin reset = 1'b1; mem_valid = 1'b0; end
        @(posedge clk);
        #1 reset = 1'b0;
        model_oor = 1'b0;
        chk("midreset_ready", 32'(mem_ready), 32'd0);
        chk("midreset_oor", 32'(oor_err), 32'd0);
        repeat (5) @(posedge clk);
        #1 chk("midreset_no_ack", 32'(ack_cnt), 32'(base_ack));
        issue(32'h14, 4'h0, 32'd0, 1'b1); wait_ack("after_reset"); idle(1);
        chk("after_reset_value", last_rdata, 32'h12BB_56DD);

        // Randomized traffic: reads/writes, bursts, idles, aborts, occasional out-of-range.
        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            logic [3:0]  s;
            a = 32'($urandom_range(0, 31)) << 2;
            if ($urandom_range(0, 9) == 0) a = 32'(WORDS + $urandom_range(0, 100)) << 2;
            s = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
            if ($urandom_range(0, 7) == 0) begin
                abort_req(a, s, $urandom);
            end else begin
                issue(a, s, $urandom, 1'b1);
                wait_ack("random");
                if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            end
        end
        idle(LAT + 4);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
